// File: rtl/booth_mult_unit.sv
// booth_mult_unit
//   Sequential radix-2 Booth multiplier for 32-bit two's-complement operands.
//   Each clock in RUN performs one Booth step. A full operation takes
//   32 RUN edges, then one DONE cycle, then the unit returns to IDLE.
//
// Ports
//   clock        in   rising-edge clock for all state
//   reset_n      in   asynchronous active-low reset
//   data_A       in   [31:0] multiplicand, sampled on the accepting edge
//   data_B       in   [31:0] multiplier, sampled on the accepting edge
//   ctrl_MULT    in   start request, honoured only in IDLE
//   result       out  [31:0] low 32 bits of the signed 64-bit product
//   overflow     out  product does not fit in 32 signed bits
//   result_ready out  one-cycle pulse while in DONE
//   busy         out  high in RUN and DONE
module booth_mult_unit (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] data_A,
  input  logic [31:0] data_B,
  input  logic        ctrl_MULT,
  output logic [31:0] result,
  output logic        overflow,
  output logic        result_ready,
  output logic        busy
);

  localparam int unsigned W  = 32;        // operand width
  localparam int unsigned AW = W + 1;     // upper accumulator width
  localparam int unsigned PW = 2 * W + 2; // product register: {upper, multiplier, booth bit}
  localparam int unsigned CW = 6;         // step counter width (0..32)

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]    state_q,  state_d;
  logic [CW-1:0] cnt_q,    cnt_d;
  logic [PW-1:0] p_q,      p_d;
  logic [W-1:0]  m_q,      m_d;
  logic [W-1:0]  result_q, result_d;
  logic          ovf_q,    ovf_d;
  logic          ready_q,  ready_d;
  logic          busy_q,   busy_d;

  // Booth step datapath
  logic [AW-1:0]  upper;
  logic [AW-1:0]  m_ext;
  logic [AW-1:0]  addend;
  logic [AW-1:0]  sum;
  logic [AW-1:0]  upper_n;
  logic           add_en;
  logic           sub_en;
  logic [PW-1:0]  p_step;
  logic [2*W-1:0] product;

  // One Booth step: optional add/subtract of sign-extended M into the
  // 33-bit upper half, then arithmetic shift of the whole register.
  // The extra accumulator bit keeps M = 0x80000000 exact.
  always_comb begin
    upper   = p_q[PW-1:W+1];
    m_ext   = {m_q[W-1], m_q};
    add_en  = p_q[1] ^ p_q[0];
    sub_en  = p_q[1] & ~p_q[0];
    // Subtract is implemented as add of the inverted operand with carry-in.
    addend  = sub_en ? ~m_ext : m_ext;
    sum     = upper + addend + AW'(sub_en);
    upper_n = add_en ? sum : upper;
    p_step  = {upper_n[AW-1], upper_n, p_q[W:1]};
    // After the final shift, bits [64:1] hold the signed 64-bit product.
    product = p_step[2*W:1];
  end

  // State register and all registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      p_q      <= '0;
      m_q      <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      p_q      <= p_d;
      m_q      <= m_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    p_d      = p_q;
    m_d      = m_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    ready_d  = 1'b0;
    busy_d   = busy_q;

    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (ctrl_MULT) begin
          state_d = ST_RUN;
          m_d     = data_A;
          p_d     = {{AW{1'b0}}, data_B, 1'b0};
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end

      ST_RUN: begin
        p_d   = p_step;
        cnt_d = cnt_q + CW'(1);
        // This edge performs step 32: publish the result and enter DONE.
        if (cnt_q == CW'(W - 1)) begin
          state_d  = ST_DONE;
          result_d = product[W-1:0];
          ovf_d    = (product[2*W-1:W] != {W{product[W-1]}});
          ready_d  = 1'b1;
        end
      end

      ST_DONE: begin
        // Start requests here are dropped; the next start is taken in IDLE.
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign result       = result_q;
  assign overflow     = ovf_q;
  assign result_ready = ready_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_booth_mult_unit.sv
// Scoreboard bench for booth_mult_unit: stimulus pushes hand-computed
// expected {overflow, result}; an independent monitor pops on each
// result_ready pulse.
module tb_booth_mult_unit;

  logic        clock;
  logic        reset_n;
  logic [31:0] data_A;
  logic [31:0] data_B;
  logic        ctrl_MULT;
  logic [31:0] result;
  logic        overflow;
  logic        result_ready;
  logic        busy;

  int passed = 0;
  int total  = 0;

  logic [32:0] exp_q[$];

  booth_mult_unit dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .data_A       (data_A),
    .data_B       (data_B),
    .ctrl_MULT    (ctrl_MULT),
    .result       (result),
    .overflow     (overflow),
    .result_ready (result_ready),
    .busy         (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  // Monitor: every pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (result_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_pulse: got result 0x%0h expected no pulse", result);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        check("result", 64'(result), 64'(e[31:0]));
        check("overflow", 64'(overflow), 64'(e[32]));
      end
    end
  end

  // Caller sits at a negedge. Drives start for one edge (E0), checks
  // latency to the pulse (E32) and returns at the negedge after E33,
  // so a following call is accepted at E34.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic eo);
    int lat;
    data_A    = a;
    data_B    = b;
    ctrl_MULT = 1'b1;
    exp_q.push_back({eo, er});
    @(negedge clock);
    ctrl_MULT = 1'b0;
    data_A    = ~a;
    data_B    = ~b;
    check("busy_after_E0", 64'(busy), 64'd1);
    lat = 0;
    while (result_ready !== 1'b1 && lat < 40) begin
      @(negedge clock);
      lat++;
    end
    check("ready_latency", 64'(lat), 64'd32);
    check("busy_in_done", 64'(busy), 64'd1);
    @(negedge clock);
    check("busy_after_done", 64'(busy), 64'd0);
    check("ready_one_cycle", 64'(result_ready), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int lat;
    reset_n   = 1'b0;
    ctrl_MULT = 1'b0;
    data_A    = '0;
    data_B    = '0;
    #1;
    check("rst_result", 64'(result), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_ready", 64'(result_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clock);

    // Start on the very first edge after reset release.
    reset_n = 1'b1;
    run_op(32'd3, 32'd5, 32'h0000000F, 1'b0);
    run_op(32'hFFFFFFF9, 32'd6, 32'hFFFFFFD6, 1'b0);
    run_op(32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1);
    run_op(32'h80000000, 32'd1, 32'h80000000, 1'b0);
    run_op(32'h00010000, 32'h00010000, 32'h00000000, 1'b1);
    run_op(32'h00000000, 32'h7FFFFFFF, 32'h00000000, 1'b0);
    run_op(32'h80000000, 32'h80000000, 32'h00000000, 1'b1);
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0);
    run_op(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h00000001, 1'b1);

    // Abort mid-run: no expectation pushed, so any pulse is flagged.
    data_A    = 32'd3;
    data_B    = 32'd5;
    ctrl_MULT = 1'b1;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    repeat (10) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("abort_result", 64'(result), 64'd0);
    check("abort_overflow", 64'(overflow), 64'd0);
    check("abort_ready", 64'(result_ready), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    run_op(32'd2, 32'd2, 32'd4, 1'b0);

    // Start requests during RUN and on the DONE exit edge are ignored.
    data_A    = 32'd3;
    data_B    = 32'd5;
    ctrl_MULT = 1'b1;
    exp_q.push_back({1'b0, 32'd15});
    @(negedge clock);
    ctrl_MULT = 1'b0;
    repeat (4) @(negedge clock);
    data_A    = 32'd9;
    data_B    = 32'd9;
    ctrl_MULT = 1'b1;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    lat = 5;
    while (result_ready !== 1'b1 && lat < 40) begin
      @(negedge clock);
      lat++;
    end
    check("ign_latency", 64'(lat), 64'd32);
    ctrl_MULT = 1'b1;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    check("ign_done_start", 64'(busy), 64'd0);
    @(negedge clock);
    check("ign_idle_busy", 64'(busy), 64'd0);
    repeat (40) @(negedge clock);
    check("ign_no_restart", 64'(busy), 64'd0);
    check("ign_result_held", 64'(result), 64'd15);

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
